// File: rtl/demux_1_8_reg.sv
// Registered 1:8 write demux into an 8-entry bank, plus an 8-cycle sequential clear engine.
// Writes land one cycle after acceptance; wr_ready drops for the whole clear sweep and the source must hold its request.
module demux_1_8_reg #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [2:0]         wr_sel,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               clr_req,
  output logic               clr_busy,
  output logic               clr_done,
  output logic [8*WIDTH-1:0] q,
  output logic [7:0]         written
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [2:0]            r_cnt;
  logic [7:0][WIDTH-1:0] r_q;
  logic [7:0]            r_written;
  logic                  r_clr_done;
  logic                  w_wr_fire;
  logic                  w_last;

  always_comb begin
    w_next_state = r_state;
    w_wr_fire    = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        w_wr_fire = wr_valid;
        if (clr_req) begin
          w_next_state = CLEAR;
        end
      end
      CLEAR: begin
        w_last = (r_cnt == 3'd7);
        if (w_last) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= 3'd0;
      r_q        <= '0;
      r_written  <= 8'h00;
      r_clr_done <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_clr_done <= w_last;
      if (w_wr_fire) begin
        r_q[wr_sel]       <= wr_data;
        r_written[wr_sel] <= 1'b1;
      end
      // Counter wraps 7->0 exactly on the CLEAR->IDLE edge, leaving it at 0 for the next sweep.
      if (r_state == CLEAR) begin
        r_q[r_cnt]       <= '0;
        r_written[r_cnt] <= 1'b0;
        r_cnt            <= r_cnt + 3'd1;
      end
    end
  end

  assign wr_ready = (r_state == IDLE);
  assign clr_busy = (r_state == CLEAR);
  assign clr_done = r_clr_done;
  assign q        = r_q;
  assign written  = r_written;

endmodule

// File: tb/tb_demux_1_8_reg.sv
// Randomized and directed bench for demux_1_8_reg against a cycle-level bank model.
module tb_demux_1_8_reg;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           wr_valid;
  logic           wr_ready;
  logic [2:0]     wr_sel;
  logic [W-1:0]   wr_data;
  logic           clr_req;
  logic           clr_busy;
  logic           clr_done;
  logic [8*W-1:0] q;
  logic [7:0]     written;

  demux_1_8_reg #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .q        (q),
    .written  (written)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: entry contents, written flags, cycles of sweep remaining (0 = idle), done pulse.
  logic [W-1:0] m_q [8];
  logic [7:0]   m_wr;
  int           m_left;
  logic         m_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8*W-1:0] model_q();
    logic [8*W-1:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[W*i +: W] = m_q[i];
    return v;
  endfunction

  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < 8; i++) m_q[i] = '0;
      m_wr   = 8'h00;
      m_left = 0;
      m_done = 1'b0;
    end else begin
      m_done = (m_left == 1);
      if (m_left == 0) begin
        if (wr_valid) begin
          m_q[wr_sel]  = wr_data;
          m_wr[wr_sel] = 1'b1;
        end
        if (clr_req) m_left = 8;
      end else begin
        m_q[8 - m_left]  = '0;
        m_wr[8 - m_left] = 1'b0;
        m_left--;
      end
    end
  endtask

  task automatic cyc(input logic r, input logic v, input logic [2:0] s,
                     input logic [W-1:0] d, input logic c);
    rst = r; wr_valid = v; wr_sel = s; wr_data = d; clr_req = c;
    @(posedge clk);
    model_edge();
    #1;
    check("q",        q,        model_q());
    check("written",  written,  m_wr);
    check("wr_ready", wr_ready, m_left == 0);
    check("clr_busy", clr_busy, m_left != 0);
    check("clr_done", clr_done, m_done);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 3'd0, '0, 0);
  endtask

  task automatic fill();
    for (int i = 0; i < 8; i++) cyc(0, 1, 3'(i), W'(i + 1), 0);
  endtask

  int done_cnt;

  initial begin
    for (int i = 0; i < 8; i++) m_q[i] = 'x;
    m_wr = 'x; m_left = 0; m_done = 1'bx;
    cyc(1, 1, 3'd2, 4'h7, 1);
    cyc(1, 0, 3'd0, 4'h0, 0);
    check("rst_q_const", q, 32'h0);

    cyc(0, 1, 3'd5, 4'hA, 0);
    check("w5_q_const",  q, 32'h00A0_0000);
    check("w5_wr_const", written, 8'h20);

    fill();
    check("fill_q_const",  q, 32'h8765_4321);
    check("fill_wr_const", written, 8'hFF);

    cyc(0, 0, 3'd0, 4'h0, 1);
    done_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      cyc(0, 0, 3'd0, 4'h0, 0);
      if (clr_done) done_cnt++;
    end
    check("clr_done_once", done_cnt, 1);
    check("clr_wr_const", written, 8'h00);

    // Write coinciding with clear start, then a held write blocked by the sweep.
    fill();
    cyc(0, 1, 3'd3, 4'hF, 1);
    for (int i = 0; i < 8; i++) cyc(0, 1, 3'd6, 4'h9, 0);
    cyc(0, 1, 3'd6, 4'h9, 0);
    idle(1);
    check("held_wr_const", written, 8'h40);

    // Reset in the middle of a sweep.
    fill();
    cyc(0, 0, 3'd0, 4'h0, 1);
    idle(4);
    cyc(1, 0, 3'd0, 4'h0, 0);
    check("midrst_q_const", q, 32'h0);
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 3'd0, 4'h0, 0);
      if (clr_done) done_cnt++;
    end
    check("midrst_no_done", done_cnt, 0);

    // Continuous clr_req: back-to-back sweeps with single idle gaps.
    fill();
    for (int i = 0; i < 30; i++) cyc(0, 1, 3'(i), 4'(i), 1);
    idle(10);

    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 99) == 0), $urandom_range(0, 1),
          3'($urandom_range(0, 7)), W'($urandom), ($urandom_range(0, 19) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
